// File: rtl/regfile_param_if.sv
// Register file access bus: decode-side read port, writeback-side write port,
// scrub request and status.
//   master: clr, rd_en, ra1, ra2, wr_en, wa, wd  ->  rd1, rd2, rd_valid, busy
//   slave : the register file side of the same signals
interface regfile_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              clr;
    logic              rd_en;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              busy;

    modport master (
        output clr, rd_en, ra1, ra2, wr_en, wa, wd,
        input  rd1, rd2, rd_valid, busy
    );

    modport slave (
        input  clr, rd_en, ra1, ra2, wr_en, wa, wd,
        output rd1, rd2, rd_valid, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port,
// optional write-to-read bypass and optional hardwired-zero entry 0.
// A scrub engine zeroes every entry after reset or on clr, so the array
// itself carries no reset.
//   clk, rst  : clock, synchronous active-high reset
//   bus.clr   : scrub request (honoured in IDLE only)
//   bus.rd_en, bus.ra1, bus.ra2 -> bus.rd1, bus.rd2, bus.rd_valid (1-cycle latency)
//   bus.wr_en, bus.wa, bus.wd   : write port
//   bus.busy  : scrub in progress, reads and writes ignored
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic           clk,
    input logic           rst,
    regfile_param_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_wa_c;
    logic [DATA_W-1:0] mem_wd_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // Resolve one read port: range, zero register, bypass, then storage.
    function automatic logic [DATA_W-1:0] read_val(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              wr,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (32'(a) >= DEPTH)                 return '0;
        if ((ZERO_REG != 0) && (a == '0))    return '0;
        if ((BYPASS != 0) && wr && (wa == a)) return wd;
        return stored;
    endfunction

    // A user write lands only in IDLE, without a competing clr, in range,
    // and never on the hardwired zero entry.
    always_comb begin
        wr_ok_c = (state == IDLE) && bus.wr_en && !bus.clr && !rst
                  && (32'(bus.wa) < DEPTH)
                  && !((ZERO_REG != 0) && (bus.wa == '0));
    end

    // Single array write port shared by the scrub engine and the user.
    always_comb begin
        mem_we_c = 1'b0;
        mem_wa_c = bus.wa;
        mem_wd_c = bus.wd;
        if (state == CLEAR) begin
            mem_we_c = 1'b1;
            mem_wa_c = ptr;
            mem_wd_c = '0;
        end else if (wr_ok_c) begin
            mem_we_c = 1'b1;
        end
    end

    always_comb begin
        rd1_c = read_val(bus.ra1, mem[bus.ra1], wr_ok_c, bus.wa, bus.wd);
        rd2_c = read_val(bus.ra2, mem[bus.ra2], wr_ok_c, bus.wa, bus.wd);
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_wa_c] <= mem_wd_c;
        end
    end

    // Scrub FSM and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            ptr        <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    rd_valid_q <= 1'b0;
                    if (ptr == LAST_PTR) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    if (bus.clr) begin
                        state      <= CLEAR;
                        ptr        <= '0;
                        busy_q     <= 1'b1;
                        rd_valid_q <= 1'b0;
                    end else begin
                        rd_valid_q <= bus.rd_en;
                        if (bus.rd_en) begin
                            rd1_q <= rd1_c;
                            rd2_q <= rd2_c;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rd1      = rd1_q;
    assign bus.rd2      = rd2_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: two register files with different parameters driven
// by identical stimulus, each compared every cycle against a behavioural model.
//   instance a: DEPTH=32, ZERO_REG=1, BYPASS=1
//   instance b: DEPTH=20, ZERO_REG=0, BYPASS=0
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        rd_en;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] wd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    assign ifa.clr = clr;   assign ifb.clr = clr;
    assign ifa.rd_en = rd_en; assign ifb.rd_en = rd_en;
    assign ifa.ra1 = ra1;   assign ifb.ra1 = ra1;
    assign ifa.ra2 = ra2;   assign ifb.ra2 = ra2;
    assign ifa.wr_en = wr_en; assign ifb.wr_en = wr_en;
    assign ifa.wa = wa;     assign ifb.wa = wa;
    assign ifa.wd = wd;     assign ifb.wd = wd;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .ZERO_REG(0), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Behavioural model state, one slot per instance.
    logic [31:0] m_mem [2][32];
    int          m_left [2];
    logic [31:0] m_rd1 [2];
    logic [31:0] m_rd2 [2];
    logic        m_v [2];

    function automatic int dep(int k);
        return (k == 0) ? 32 : 20;
    endfunction
    function automatic bit zr(int k);
        return k == 0;
    endfunction
    function automatic bit byp(int k);
        return k == 0;
    endfunction

    function automatic logic [31:0] mval(int k, logic [4:0] a, bit wacc);
        if (int'(a) >= dep(k))             return 32'd0;
        if (zr(k) && a == 5'd0)            return 32'd0;
        if (byp(k) && wacc && wa == a)     return wd;
        return m_mem[k][a];
    endfunction

    task automatic model_edge(int k);
        bit wacc;
        wacc = (m_left[k] == 0) && wr_en && !clr && (int'(wa) < dep(k))
               && !(zr(k) && wa == 5'd0);
        if (rst) begin
            m_rd1[k]  = 32'd0;
            m_rd2[k]  = 32'd0;
            m_v[k]    = 1'b0;
            m_left[k] = dep(k);
            for (int i = 0; i < 32; i++) m_mem[k][i] = 32'd0;
        end else if (m_left[k] > 0) begin
            m_left[k]--;
            m_v[k] = 1'b0;
        end else if (clr) begin
            m_left[k] = dep(k);
            m_v[k]    = 1'b0;
            for (int i = 0; i < 32; i++) m_mem[k][i] = 32'd0;
        end else begin
            m_v[k] = rd_en;
            if (rd_en) begin
                m_rd1[k] = mval(k, ra1, wacc);
                m_rd2[k] = mval(k, ra2, wacc);
            end
            if (wacc) m_mem[k][wa] = wd;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.busy",  32'(ifa.busy),     32'(m_left[0] != 0));
        chk("a.valid", 32'(ifa.rd_valid), 32'(m_v[0]));
        chk("a.rd1",   ifa.rd1,           m_rd1[0]);
        chk("a.rd2",   ifa.rd2,           m_rd2[0]);
        chk("b.busy",  32'(ifb.busy),     32'(m_left[1] != 0));
        chk("b.valid", 32'(ifb.rd_valid), 32'(m_v[1]));
        chk("b.rd1",   ifb.rd1,           m_rd1[1]);
        chk("b.rd2",   ifb.rd2,           m_rd2[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic do_write(logic [4:0] a, logic [31:0] d);
        idle_inputs();
        wr_en = 1'b1; wa = a; wd = d;
        step();
    endtask

    task automatic do_read(logic [4:0] a1, logic [4:0] a2);
        idle_inputs();
        rd_en = 1'b1; ra1 = a1; ra2 = a2;
        step();
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        idle_inputs();
        while ((ifa.busy || ifb.busy) && n < budget) begin
            step();
            n++;
        end
        chk("scrub_done", 32'(ifa.busy | ifb.busy), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_rd1[k] = 0; m_rd2[k] = 0; m_v[k] = 0;
            for (int i = 0; i < 32; i++) m_mem[k][i] = 32'd0;
        end
        ra1 = '0; ra2 = '0; wa = '0; wd = '0;

        // Reset scrub; a write during busy must be ignored.
        idle_inputs();
        rst = 1'b1;
        step();
        idle_inputs();
        wr_en = 1'b1; wa = 5'd3; wd = 32'd55;
        for (int i = 0; i < 31; i++) step();
        chk("plan1.busy_at_31", 32'(ifa.busy), 32'd1);
        step();
        chk("plan1.busy_at_32", 32'(ifa.busy), 32'd0);
        do_read(5'd7, 5'd31);
        chk("plan1.rd1", ifa.rd1, 32'd0);
        chk("plan1.rd2", ifa.rd2, 32'd0);
        chk("plan1.valid", 32'(ifa.rd_valid), 32'd1);
        do_read(5'd3, 5'd3);
        chk("plan1.busy_write", ifa.rd1, 32'd0);

        // Write then read, outputs hold afterwards.
        do_write(5'd30, 32'd111111);
        do_write(5'd10, 32'd9999999);
        do_read(5'd30, 5'd10);
        chk("plan2.rd1", ifa.rd1, 32'd111111);
        chk("plan2.rd2", ifa.rd2, 32'd9999999);
        idle_inputs();
        step();
        chk("plan2.hold", ifa.rd1, 32'd111111);
        chk("plan2.valid_low", 32'(ifa.rd_valid), 32'd0);

        // Bypass vs no bypass.
        idle_inputs();
        wr_en = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; rd_en = 1'b1; ra1 = 5'd5; ra2 = 5'd5;
        step();
        chk("plan3.bypass", ifa.rd1, 32'hDEADBEEF);
        chk("plan3.nobypass", ifb.rd1, 32'd0);
        do_read(5'd5, 5'd5);
        chk("plan3.second_read", ifb.rd1, 32'hDEADBEEF);

        // Zero register, also with a same-cycle write.
        do_write(5'd0, 32'h1234);
        do_read(5'd0, 5'd0);
        chk("plan4.zero", ifa.rd1, 32'd0);
        chk("plan4.nozero", ifb.rd1, 32'h1234);
        idle_inputs();
        wr_en = 1'b1; wa = 5'd0; wd = 32'h5555; rd_en = 1'b1; ra1 = 5'd0;
        step();
        chk("plan4.zero_bypass", ifa.rd1, 32'd0);

        // clr with a competing write, then reset mid-scrub.
        do_write(5'd1, 32'd1);
        do_write(5'd2, 32'd2);
        do_write(5'd3, 32'd3);
        idle_inputs();
        clr = 1'b1; wr_en = 1'b1; wa = 5'd4; wd = 32'd44;
        step();
        wait_idle(40);
        do_read(5'd1, 5'd2);
        chk("plan5.e1", ifa.rd1, 32'd0);
        do_read(5'd3, 5'd4);
        chk("plan5.e4", ifa.rd2, 32'd0);
        idle_inputs();
        clr = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 31; i++) step();
        chk("plan5.restart_31", 32'(ifa.busy), 32'd1);
        step();
        chk("plan5.restart_32", 32'(ifa.busy), 32'd0);

        // Depth boundary (instance b has 20 entries).
        do_write(5'd25, 32'd77);
        do_write(5'd19, 32'h1919);
        do_read(5'd25, 5'd19);
        chk("plan6.oob", ifb.rd1, 32'd0);
        chk("plan6.last", ifb.rd2, 32'h1919);
        chk("plan6.a_25", ifa.rd1, 32'd77);

        // Randomised traffic with occasional scrubs and resets.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            clr   = ($urandom_range(0, 79) == 0);
            rd_en = $urandom_range(0, 1) == 1;
            wr_en = $urandom_range(0, 1) == 1;
            ra1   = 5'($urandom_range(0, 31));
            ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
            wa    = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom_range(0, 31));
            wd    = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised, clocked successor to the team's 32x32 register file.
- Provides two registered read ports and one write port, with configurable width and depth.
- Optional write-to-read bypass and an optional hardwired-zero register 0.
- A scrub state machine clears the whole array after reset or on request, so the array itself needs no reset.
- Sits in the datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, word width in bits
ADDR_W, 5, address width
DEPTH, 32, number of entries (1..2**ADDR_W)
ZERO_REG, 1, 1: entry 0 always reads 0 and writes to it are dropped
BYPASS, 1, 1: same-cycle write data is forwarded to a matching read

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  request to scrub (zero) all entries; sampled in IDLE only
rd_en  in  1  read strobe
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  read data, port 1 (registered)
rd2  out  DATA_W  read data, port 2 (registered)
rd_valid  out  1  rd1/rd2 hold data for a read accepted on the previous edge
wr_en  in  1  write strobe
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
busy  out  1  scrub in progress; reads and writes are ignored

Behaviour:
- Reset (rst=1 at an edge):
  - rd1=0, rd2=0, rd_valid=0.
  - FSM goes to CLEAR with ptr=0 and busy=1.
  - Applies mid-scrub as well: the scrub restarts from ptr=0.
  - Reset overrides clr, rd_en and wr_en.
- FSM states are IDLE and CLEAR.
- CLEAR:
  - Each edge writes 0 to entry ptr; ptr then increments.
  - At the edge where ptr==DEPTH-1: entry cleared, go to IDLE, busy=0 from that edge onward.
  - Scrub takes exactly DEPTH cycles; busy is high for DEPTH cycles after rst deasserts.
  - wr_en and rd_en are ignored; rd_valid=0; rd1/rd2 hold their values.
- IDLE with clr=1 at an edge:
  - Go to CLEAR with ptr=0 and busy=1.
  - A wr_en or rd_en in the same cycle is dropped.
- Write (IDLE, wr_en=1, clr=0):
  - mem[wa]<=wd at the edge.
  - Dropped if wa>=DEPTH, or if ZERO_REG=1 and wa==0.
- Read (IDLE, rd_en=1, clr=0): one-cycle latency.
  - At edge N, rd1<=value(ra1) and rd2<=value(ra2); rd_valid=1 after edge N.
  - rd_valid falls to 0 after any edge without an accepted read.
  - rd1/rd2 hold their last value when no read is accepted.
- Read value(a), in priority order:
  1. 0 if a>=DEPTH.
  2. 0 if ZERO_REG=1 and a==0.
  3. wd if BYPASS=1, an accepted write is in the same cycle, and wa==a.
  4. Otherwise the stored mem[a].
- BYPASS=0: a same-cycle read returns the old contents; the new value is visible from the next read.
- Both ports may address the same entry; both return the same value.
- Array contents are undefined until the first scrub completes. Reset always scrubs, so this is never visible to the user.
- No combinational path from any input to any output.

Test Plan:
1. Reset scrub (DEPTH=32):
   - rst high 1 cycle -> busy=1 for exactly 32 cycles, then 0.
   - A wr_en during busy is ignored.
   - Afterwards a read of ra1=7, ra2=31 -> rd1=0, rd2=0, rd_valid=1.
2. Write then read:
   - Write wd=111111 to wa=30, then wd=9999999 to wa=10.
   - rd_en with ra1=30, ra2=10 -> next cycle rd1=111111, rd2=9999999, rd_valid=1.
   - Outputs hold with rd_valid=0 on the following idle cycle.
3. Bypass:
   - BYPASS=1: wr_en wa=5 wd=0xDEADBEEF with rd_en ra1=5 in the same cycle -> rd1=0xDEADBEEF next cycle.
   - BYPASS=0, same stimulus -> rd1=old value (0).
   - A second read -> 0xDEADBEEF.
4. Zero register:
   - ZERO_REG=1: write 0x1234 to wa=0, then read ra1=0 -> rd1=0, including with a same-cycle write (bypass suppressed).
   - ZERO_REG=0: same sequence -> rd1=0x1234.
5. clr and reset mid-operation:
   - Fill entries 1..3 with 1, 2, 3.
   - Assert clr together with wr_en (wa=4) -> write dropped, busy 32 cycles, entries 1..4 read 0.
   - Assert rst at scrub cycle 10 -> busy lasts 32 more cycles from the restart.
6. Depth boundary (DEPTH=20, ADDR_W=5):
   - Write to wa=25 is dropped.
   - Read ra1=25 -> rd1=0.
   - Read ra2=19 returns the last value written there.
   - Scrub lasts 20 cycles.
